// File: rtl/axi_sram_arbiter.sv
// Two-master AXI4 arbiter in front of a single-port SRAM slave; grants whole transactions.
// Optional macro ARB_RR_EN selects round-robin arbitration; otherwise s0 has fixed priority.
module axi_sram_arbiter #(
   parameter int AXI_ADDR_W = 64,
   parameter int AXI_ID_W   = 8,
   parameter int AXI_DATA_W = 64
) (
   input  logic                    aclk,
   input  logic                    arst,
   input  logic                    s0_awvalid,
   input  logic [AXI_ADDR_W-1:0]   s0_awaddr,
   input  logic [7:0]              s0_awlen,
   input  logic [2:0]              s0_awsize,
   input  logic [1:0]              s0_awburst,
   input  logic                    s0_awlock,
   input  logic [3:0]              s0_awcache,
   input  logic [2:0]              s0_awprot,
   input  logic [3:0]              s0_awqos,
   input  logic [3:0]              s0_awregion,
   input  logic [AXI_ID_W-1:0]     s0_awid,
   output logic                    s0_awready,
   input  logic                    s0_wvalid,
   input  logic                    s0_wlast,
   input  logic [AXI_DATA_W-1:0]   s0_wdata,
   input  logic [AXI_DATA_W/8-1:0] s0_wstrb,
   output logic                    s0_wready,
   output logic                    s0_bvalid,
   output logic [AXI_ID_W-1:0]     s0_bid,
   output logic [1:0]              s0_bresp,
   input  logic                    s0_bready,
   input  logic                    s0_arvalid,
   input  logic [AXI_ADDR_W-1:0]   s0_araddr,
   input  logic [7:0]              s0_arlen,
   input  logic [2:0]              s0_arsize,
   input  logic [1:0]              s0_arburst,
   input  logic                    s0_arlock,
   input  logic [3:0]              s0_arcache,
   input  logic [2:0]              s0_arprot,
   input  logic [3:0]              s0_arqos,
   input  logic [3:0]              s0_arregion,
   input  logic [AXI_ID_W-1:0]     s0_arid,
   output logic                    s0_arready,
   output logic                    s0_rvalid,
   output logic [AXI_ID_W-1:0]     s0_rid,
   output logic [1:0]              s0_rresp,
   output logic [AXI_DATA_W-1:0]   s0_rdata,
   output logic                    s0_rlast,
   input  logic                    s0_rready,
   input  logic                    s1_awvalid,
   input  logic [AXI_ADDR_W-1:0]   s1_awaddr,
   input  logic [7:0]              s1_awlen,
   input  logic [2:0]              s1_awsize,
   input  logic [1:0]              s1_awburst,
   input  logic                    s1_awlock,
   input  logic [3:0]              s1_awcache,
   input  logic [2:0]              s1_awprot,
   input  logic [3:0]              s1_awqos,
   input  logic [3:0]              s1_awregion,
   input  logic [AXI_ID_W-1:0]     s1_awid,
   output logic                    s1_awready,
   input  logic                    s1_wvalid,
   input  logic                    s1_wlast,
   input  logic [AXI_DATA_W-1:0]   s1_wdata,
   input  logic [AXI_DATA_W/8-1:0] s1_wstrb,
   output logic                    s1_wready,
   output logic                    s1_bvalid,
   output logic [AXI_ID_W-1:0]     s1_bid,
   output logic [1:0]              s1_bresp,
   input  logic                    s1_bready,
   input  logic                    s1_arvalid,
   input  logic [AXI_ADDR_W-1:0]   s1_araddr,
   input  logic [7:0]              s1_arlen,
   input  logic [2:0]              s1_arsize,
   input  logic [1:0]              s1_arburst,
   input  logic                    s1_arlock,
   input  logic [3:0]              s1_arcache,
   input  logic [2:0]              s1_arprot,
   input  logic [3:0]              s1_arqos,
   input  logic [3:0]              s1_arregion,
   input  logic [AXI_ID_W-1:0]     s1_arid,
   output logic                    s1_arready,
   output logic                    s1_rvalid,
   output logic [AXI_ID_W-1:0]     s1_rid,
   output logic [1:0]              s1_rresp,
   output logic [AXI_DATA_W-1:0]   s1_rdata,
   output logic                    s1_rlast,
   input  logic                    s1_rready,
   output logic                    mst_awvalid,
   output logic [AXI_ADDR_W-1:0]   mst_awaddr,
   output logic [7:0]              mst_awlen,
   output logic [2:0]              mst_awsize,
   output logic [1:0]              mst_awburst,
   output logic                    mst_awlock,
   output logic [3:0]              mst_awcache,
   output logic [2:0]              mst_awprot,
   output logic [3:0]              mst_awqos,
   output logic [3:0]              mst_awregion,
   output logic [AXI_ID_W-1:0]     mst_awid,
   input  logic                    mst_awready,
   output logic                    mst_wvalid,
   output logic                    mst_wlast,
   output logic [AXI_DATA_W-1:0]   mst_wdata,
   output logic [AXI_DATA_W/8-1:0] mst_wstrb,
   input  logic                    mst_wready,
   input  logic                    mst_bvalid,
   input  logic [AXI_ID_W-1:0]     mst_bid,
   input  logic [1:0]              mst_bresp,
   output logic                    mst_bready,
   output logic                    mst_arvalid,
   output logic [AXI_ADDR_W-1:0]   mst_araddr,
   output logic [7:0]              mst_arlen,
   output logic [2:0]              mst_arsize,
   output logic [1:0]              mst_arburst,
   output logic                    mst_arlock,
   output logic [3:0]              mst_arcache,
   output logic [2:0]              mst_arprot,
   output logic [3:0]              mst_arqos,
   output logic [3:0]              mst_arregion,
   output logic [AXI_ID_W-1:0]     mst_arid,
   input  logic                    mst_arready,
   input  logic                    mst_rvalid,
   input  logic [AXI_ID_W-1:0]     mst_rid,
   input  logic [1:0]              mst_rresp,
   input  logic [AXI_DATA_W-1:0]   mst_rdata,
   input  logic                    mst_rlast,
   output logic                    mst_rready
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_ADDR = 3'd3,
      WR_DATA = 3'd4,
      WR_RESP = 3'd5
   } state_t;

   state_t state_q, state_d;
   logic   grant_q, grant_d;
   logic   req0_s, req1_s, sel_s, sel_ar_s, txn_done_s;

   assign req0_s   = s0_arvalid | s0_awvalid;
   assign req1_s   = s1_arvalid | s1_awvalid;
   assign sel_ar_s = sel_s ? s1_arvalid : s0_arvalid;
   assign txn_done_s = ((state_q == RD_DATA) & mst_rvalid & mst_rready & mst_rlast) |
                       ((state_q == WR_RESP) & mst_bvalid & mst_bready);

`ifdef ARB_RR_EN
   logic rr_ptr_q, rr_ptr_d;

   // Favoured master wins if it is requesting, otherwise the other one.
   assign sel_s    = (rr_ptr_q ? req1_s : req0_s) ? rr_ptr_q : ~rr_ptr_q;
   assign rr_ptr_d = txn_done_s ? ~grant_q : rr_ptr_q;

   // Round-robin pointer register.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   assign sel_s = ~req0_s;
`endif

   // State and grant registers.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   // Next-state logic; a grant is held until the transaction's final handshake.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (req0_s | req1_s) begin
               grant_d = sel_s;
               state_d = sel_ar_s ? RD_ADDR : WR_ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         RD_ADDR: state_d = (mst_arvalid & mst_arready) ? RD_DATA : RD_ADDR;
         RD_DATA: state_d = txn_done_s ? IDLE : RD_DATA;
         WR_ADDR: state_d = (mst_awvalid & mst_awready) ? WR_DATA : WR_ADDR;
         WR_DATA: state_d = (mst_wvalid & mst_wready & mst_wlast) ? WR_RESP : WR_DATA;
         WR_RESP: state_d = txn_done_s ? IDLE : WR_RESP;
         default: state_d = IDLE;
      endcase
   end

   // Handshake routing: only the channel owned by the current state is live.
   always_comb begin
      mst_arvalid = 1'b0;
      mst_awvalid = 1'b0;
      mst_wvalid  = 1'b0;
      mst_rready  = 1'b0;
      mst_bready  = 1'b0;
      s0_arready  = 1'b0;
      s1_arready  = 1'b0;
      s0_awready  = 1'b0;
      s1_awready  = 1'b0;
      s0_wready   = 1'b0;
      s1_wready   = 1'b0;
      s0_rvalid   = 1'b0;
      s1_rvalid   = 1'b0;
      s0_bvalid   = 1'b0;
      s1_bvalid   = 1'b0;
      case (state_q)
         RD_ADDR: begin
            mst_arvalid = grant_q ? s1_arvalid : s0_arvalid;
            s0_arready  = ~grant_q & mst_arready;
            s1_arready  = grant_q & mst_arready;
         end
         RD_DATA: begin
            mst_rready = grant_q ? s1_rready : s0_rready;
            s0_rvalid  = ~grant_q & mst_rvalid;
            s1_rvalid  = grant_q & mst_rvalid;
         end
         WR_ADDR: begin
            mst_awvalid = grant_q ? s1_awvalid : s0_awvalid;
            s0_awready  = ~grant_q & mst_awready;
            s1_awready  = grant_q & mst_awready;
         end
         WR_DATA: begin
            mst_wvalid = grant_q ? s1_wvalid : s0_wvalid;
            s0_wready  = ~grant_q & mst_wready;
            s1_wready  = grant_q & mst_wready;
         end
         WR_RESP: begin
            mst_bready = grant_q ? s1_bready : s0_bready;
            s0_bvalid  = ~grant_q & mst_bvalid;
            s1_bvalid  = grant_q & mst_bvalid;
         end
         default: begin
            mst_arvalid = 1'b0;
         end
      endcase
   end

   // Payloads follow the grant unconditionally; their valids qualify them.
   assign mst_awaddr   = grant_q ? s1_awaddr   : s0_awaddr;
   assign mst_awlen    = grant_q ? s1_awlen    : s0_awlen;
   assign mst_awsize   = grant_q ? s1_awsize   : s0_awsize;
   assign mst_awburst  = grant_q ? s1_awburst  : s0_awburst;
   assign mst_awlock   = grant_q ? s1_awlock   : s0_awlock;
   assign mst_awcache  = grant_q ? s1_awcache  : s0_awcache;
   assign mst_awprot   = grant_q ? s1_awprot   : s0_awprot;
   assign mst_awqos    = grant_q ? s1_awqos    : s0_awqos;
   assign mst_awregion = grant_q ? s1_awregion : s0_awregion;
   assign mst_awid     = grant_q ? s1_awid     : s0_awid;
   assign mst_wlast    = grant_q ? s1_wlast    : s0_wlast;
   assign mst_wdata    = grant_q ? s1_wdata    : s0_wdata;
   assign mst_wstrb    = grant_q ? s1_wstrb    : s0_wstrb;
   assign mst_araddr   = grant_q ? s1_araddr   : s0_araddr;
   assign mst_arlen    = grant_q ? s1_arlen    : s0_arlen;
   assign mst_arsize   = grant_q ? s1_arsize   : s0_arsize;
   assign mst_arburst  = grant_q ? s1_arburst  : s0_arburst;
   assign mst_arlock   = grant_q ? s1_arlock   : s0_arlock;
   assign mst_arcache  = grant_q ? s1_arcache  : s0_arcache;
   assign mst_arprot   = grant_q ? s1_arprot   : s0_arprot;
   assign mst_arqos    = grant_q ? s1_arqos    : s0_arqos;
   assign mst_arregion = grant_q ? s1_arregion : s0_arregion;
   assign mst_arid     = grant_q ? s1_arid     : s0_arid;

   assign s0_rid   = mst_rid;
   assign s1_rid   = mst_rid;
   assign s0_rresp = mst_rresp;
   assign s1_rresp = mst_rresp;
   assign s0_rdata = mst_rdata;
   assign s1_rdata = mst_rdata;
   assign s0_rlast = mst_rlast;
   assign s1_rlast = mst_rlast;
   assign s0_bid   = mst_bid;
   assign s1_bid   = mst_bid;
   assign s0_bresp = mst_bresp;
   assign s1_bresp = mst_bresp;

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Scoreboard bench for axi_sram_arbiter with a small behavioural SRAM slave on mst_*.
module tb_axi_sram_arbiter;
   logic aclk = 1'b0;
   logic arst = 1'b1;
   always #5 aclk = ~aclk;

   logic        s0_awvalid, s0_awlock, s0_awready, s0_wvalid, s0_wlast, s0_wready, s0_bvalid, s0_bready;
   logic        s0_arvalid, s0_arlock, s0_arready, s0_rvalid, s0_rlast, s0_rready;
   logic [63:0] s0_awaddr, s0_araddr, s0_wdata, s0_rdata;
   logic [7:0]  s0_awlen, s0_arlen, s0_awid, s0_arid, s0_bid, s0_rid, s0_wstrb;
   logic [2:0]  s0_awsize, s0_arsize, s0_awprot, s0_arprot;
   logic [1:0]  s0_awburst, s0_arburst, s0_bresp, s0_rresp;
   logic [3:0]  s0_awcache, s0_arcache, s0_awqos, s0_arqos, s0_awregion, s0_arregion;
   logic        s1_awvalid, s1_awlock, s1_awready, s1_wvalid, s1_wlast, s1_wready, s1_bvalid, s1_bready;
   logic        s1_arvalid, s1_arlock, s1_arready, s1_rvalid, s1_rlast, s1_rready;
   logic [63:0] s1_awaddr, s1_araddr, s1_wdata, s1_rdata;
   logic [7:0]  s1_awlen, s1_arlen, s1_awid, s1_arid, s1_bid, s1_rid, s1_wstrb;
   logic [2:0]  s1_awsize, s1_arsize, s1_awprot, s1_arprot;
   logic [1:0]  s1_awburst, s1_arburst, s1_bresp, s1_rresp;
   logic [3:0]  s1_awcache, s1_arcache, s1_awqos, s1_arqos, s1_awregion, s1_arregion;
   logic        mst_awvalid, mst_awlock, mst_awready, mst_wvalid, mst_wlast, mst_wready, mst_bvalid, mst_bready;
   logic        mst_arvalid, mst_arlock, mst_arready, mst_rvalid, mst_rlast, mst_rready;
   logic [63:0] mst_awaddr, mst_araddr, mst_wdata, mst_rdata;
   logic [7:0]  mst_awlen, mst_arlen, mst_awid, mst_arid, mst_bid, mst_rid, mst_wstrb;
   logic [2:0]  mst_awsize, mst_arsize, mst_awprot, mst_arprot;
   logic [1:0]  mst_awburst, mst_arburst, mst_bresp, mst_rresp;
   logic [3:0]  mst_awcache, mst_arcache, mst_awqos, mst_arqos, mst_awregion, mst_arregion;

   axi_sram_arbiter dut (
      .aclk(aclk), .arst(arst),
      .s0_awvalid(s0_awvalid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
      .s0_awburst(s0_awburst), .s0_awlock(s0_awlock), .s0_awcache(s0_awcache), .s0_awprot(s0_awprot),
      .s0_awqos(s0_awqos), .s0_awregion(s0_awregion), .s0_awid(s0_awid), .s0_awready(s0_awready),
      .s0_wvalid(s0_wvalid), .s0_wlast(s0_wlast), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wready(s0_wready),
      .s0_bvalid(s0_bvalid), .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bready(s0_bready),
      .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
      .s0_arburst(s0_arburst), .s0_arlock(s0_arlock), .s0_arcache(s0_arcache), .s0_arprot(s0_arprot),
      .s0_arqos(s0_arqos), .s0_arregion(s0_arregion), .s0_arid(s0_arid), .s0_arready(s0_arready),
      .s0_rvalid(s0_rvalid), .s0_rid(s0_rid), .s0_rresp(s0_rresp), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast),
      .s0_rready(s0_rready),
      .s1_awvalid(s1_awvalid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
      .s1_awburst(s1_awburst), .s1_awlock(s1_awlock), .s1_awcache(s1_awcache), .s1_awprot(s1_awprot),
      .s1_awqos(s1_awqos), .s1_awregion(s1_awregion), .s1_awid(s1_awid), .s1_awready(s1_awready),
      .s1_wvalid(s1_wvalid), .s1_wlast(s1_wlast), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wready(s1_wready),
      .s1_bvalid(s1_bvalid), .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bready(s1_bready),
      .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
      .s1_arburst(s1_arburst), .s1_arlock(s1_arlock), .s1_arcache(s1_arcache), .s1_arprot(s1_arprot),
      .s1_arqos(s1_arqos), .s1_arregion(s1_arregion), .s1_arid(s1_arid), .s1_arready(s1_arready),
      .s1_rvalid(s1_rvalid), .s1_rid(s1_rid), .s1_rresp(s1_rresp), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast),
      .s1_rready(s1_rready),
      .mst_awvalid(mst_awvalid), .mst_awaddr(mst_awaddr), .mst_awlen(mst_awlen), .mst_awsize(mst_awsize),
      .mst_awburst(mst_awburst), .mst_awlock(mst_awlock), .mst_awcache(mst_awcache), .mst_awprot(mst_awprot),
      .mst_awqos(mst_awqos), .mst_awregion(mst_awregion), .mst_awid(mst_awid), .mst_awready(mst_awready),
      .mst_wvalid(mst_wvalid), .mst_wlast(mst_wlast), .mst_wdata(mst_wdata), .mst_wstrb(mst_wstrb),
      .mst_wready(mst_wready), .mst_bvalid(mst_bvalid), .mst_bid(mst_bid), .mst_bresp(mst_bresp),
      .mst_bready(mst_bready),
      .mst_arvalid(mst_arvalid), .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
      .mst_arburst(mst_arburst), .mst_arlock(mst_arlock), .mst_arcache(mst_arcache), .mst_arprot(mst_arprot),
      .mst_arqos(mst_arqos), .mst_arregion(mst_arregion), .mst_arid(mst_arid), .mst_arready(mst_arready),
      .mst_rvalid(mst_rvalid), .mst_rid(mst_rid), .mst_rresp(mst_rresp), .mst_rdata(mst_rdata),
      .mst_rlast(mst_rlast), .mst_rready(mst_rready)
   );

   // Behavioural SRAM slave: rdata = {0xCAFE_00<beat>, addr[31:0]}; addr[31]==0 is out of range (SLVERR).
   typedef enum logic [1:0] {SL_IDLE = 2'd0, SL_R = 2'd1, SL_W = 2'd2, SL_B = 2'd3} sl_t;
   sl_t         sst;
   logic [63:0] sl_addr;
   logic [7:0]  sl_len, sl_beat, sl_id;

   assign mst_arready = (sst == SL_IDLE);
   assign mst_awready = (sst == SL_IDLE);
   assign mst_wready  = (sst == SL_W);
   assign mst_rvalid  = (sst == SL_R);
   assign mst_bvalid  = (sst == SL_B);
   assign mst_rdata   = {32'hCAFE_0000 | {24'h00_0000, sl_beat}, sl_addr[31:0]};
   assign mst_rresp   = sl_addr[31] ? 2'b00 : 2'b10;
   assign mst_bresp   = sl_addr[31] ? 2'b00 : 2'b10;
   assign mst_rlast   = (sl_beat == sl_len);
   assign mst_rid     = sl_id;
   assign mst_bid     = sl_id;

   always @(posedge aclk or posedge arst) begin
      if (arst) begin
         sst <= SL_IDLE; sl_addr <= 64'd0; sl_len <= 8'd0; sl_beat <= 8'd0; sl_id <= 8'd0;
      end else begin
         case (sst)
            SL_IDLE: if (mst_arvalid) begin
                        sl_addr <= mst_araddr; sl_len <= mst_arlen; sl_id <= mst_arid;
                        sl_beat <= 8'd0; sst <= SL_R;
                     end else if (mst_awvalid) begin
                        sl_addr <= mst_awaddr; sl_id <= mst_awid; sst <= SL_W;
                     end
            SL_R:    if (mst_rready) begin
                        if (mst_rlast) sst <= SL_IDLE;
                        else sl_beat <= sl_beat + 8'd1;
                     end
            SL_W:    if (mst_wvalid && mst_wlast) sst <= SL_B;
            default: if (mst_bready) sst <= SL_IDLE;
         endcase
      end
   end

   int total = 0;
   int bad   = 0;
   int viol  = 0;
   logic [127:0] exp_g[$], exp_r0[$], exp_r1[$], exp_w[$], exp_b0[$], exp_b1[$];

   logic [14:0] hs_outs;
   assign hs_outs = {s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid,
                     s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid,
                     mst_awvalid, mst_wvalid, mst_bready, mst_arvalid, mst_rready};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_msg(input string name);
      total++;
      bad++;
      $display("FAIL %s: event without expectation or bound expired", name);
   endtask

   function automatic void push_g(input logic wr, input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len);
      exp_g.push_back(128'({wr, id, addr, len}));
   endfunction

   function automatic void push_r(input int m, input logic [63:0] addr, input int len, input logic [7:0] id, input int nb);
      for (int k = 0; k < nb; k++) begin
         logic [127:0] rec;
         rec = 128'({32'hCAFE_0000 | 32'(k), addr[31:0], (addr[31] ? 2'b00 : 2'b10), (k == len), id});
         if (m == 0) exp_r0.push_back(rec);
         else exp_r1.push_back(rec);
      end
   endfunction

   // Monitor: pops expectations whenever the DUT presents a handshake; also watches invariants.
   initial begin
      logic aw_open;
      logic [127:0] e;
      aw_open = 1'b0;
      forever begin
         @(negedge aclk);
         if (arst) begin
            aw_open = 1'b0;
         end else begin
            if ((|hs_outs[14:10]) && (|hs_outs[9:5])) begin
               viol++;
               if (viol < 4) $display("FAIL both_masters_active: got %b expected one side idle", hs_outs);
            end
            if (mst_wvalid && !aw_open) begin
               viol++;
               if (viol < 4) $display("FAIL w_before_aw: got wvalid=1 expected 0");
            end
            if (mst_arvalid && mst_arready) begin
               if (exp_g.size() == 0) fail_msg("grant_extra");
               else begin e = exp_g.pop_front(); chk("grant_ar", 128'({1'b0, mst_arid, mst_araddr, mst_arlen}), e); end
            end
            if (mst_awvalid && mst_awready) begin
               aw_open = 1'b1;
               if (exp_g.size() == 0) fail_msg("grant_extra");
               else begin e = exp_g.pop_front(); chk("grant_aw", 128'({1'b1, mst_awid, mst_awaddr, mst_awlen}), e); end
            end
            if (mst_wvalid && mst_wready) begin
               if (exp_w.size() == 0) fail_msg("w_extra");
               else begin e = exp_w.pop_front(); chk("wbeat", 128'({mst_wdata, mst_wstrb, mst_wlast}), e); end
            end
            if (s0_rvalid && s0_rready) begin
               if (exp_r0.size() == 0) fail_msg("r0_extra");
               else begin e = exp_r0.pop_front(); chk("s0_rbeat", 128'({s0_rdata, s0_rresp, s0_rlast, s0_rid}), e); end
            end
            if (s1_rvalid && s1_rready) begin
               if (exp_r1.size() == 0) fail_msg("r1_extra");
               else begin e = exp_r1.pop_front(); chk("s1_rbeat", 128'({s1_rdata, s1_rresp, s1_rlast, s1_rid}), e); end
            end
            if (s0_bvalid && s0_bready) begin
               if (exp_b0.size() == 0) fail_msg("b0_extra");
               else begin e = exp_b0.pop_front(); chk("s0_bresp", 128'({s0_bid, s0_bresp}), e); end
            end
            if (s1_bvalid && s1_bready) begin
               if (exp_b1.size() == 0) fail_msg("b1_extra");
               else begin e = exp_b1.pop_front(); chk("s1_bresp", 128'({s1_bid, s1_bresp}), e); end
            end
            if (mst_bvalid && mst_bready) aw_open = 1'b0;
         end
      end
   end

   task automatic do_read(input int m, input logic [63:0] addr, input logic [7:0] len, input logic [7:0] id);
      int n;
      if (m == 0) begin s0_arvalid = 1'b1; s0_araddr = addr; s0_arlen = len; s0_arid = id; end
      else begin s1_arvalid = 1'b1; s1_araddr = addr; s1_arlen = len; s1_arid = id; end
      n = 0;
      @(negedge aclk);
      while (!((m == 0) ? s0_arready : s1_arready) && n < 200) begin @(negedge aclk); n++; end
      if (n >= 200) fail_msg("ar_timeout");
      @(posedge aclk); #1;
      if (m == 0) s0_arvalid = 1'b0;
      else s1_arvalid = 1'b0;
   endtask

   // Drives AW and W concurrently so early write data is visible to the arbiter.
   task automatic do_write(input int m, input logic [63:0] addr, input logic [7:0] len, input logic [7:0] id,
                           input logic [63:0] base);
      fork
         begin
            int n;
            if (m == 0) begin s0_awvalid = 1'b1; s0_awaddr = addr; s0_awlen = len; s0_awid = id; end
            else begin s1_awvalid = 1'b1; s1_awaddr = addr; s1_awlen = len; s1_awid = id; end
            n = 0;
            @(negedge aclk);
            while (!((m == 0) ? s0_awready : s1_awready) && n < 200) begin @(negedge aclk); n++; end
            if (n >= 200) fail_msg("aw_timeout");
            @(posedge aclk); #1;
            if (m == 0) s0_awvalid = 1'b0;
            else s1_awvalid = 1'b0;
         end
         begin
            for (int k = 0; k <= int'(len); k++) begin
               int n;
               if (m == 0) begin
                  s0_wvalid = 1'b1; s0_wdata = base + 64'(k); s0_wstrb = k[0] ? 8'h0F : 8'hFF; s0_wlast = (k == int'(len));
               end else begin
                  s1_wvalid = 1'b1; s1_wdata = base + 64'(k); s1_wstrb = k[0] ? 8'h0F : 8'hFF; s1_wlast = (k == int'(len));
               end
               n = 0;
               @(negedge aclk);
               while (!((m == 0) ? s0_wready : s1_wready) && n < 200) begin @(negedge aclk); n++; end
               if (n >= 200) fail_msg("w_timeout");
               @(posedge aclk); #1;
            end
            if (m == 0) begin s0_wvalid = 1'b0; s0_wlast = 1'b0; end
            else begin s1_wvalid = 1'b0; s1_wlast = 1'b0; end
         end
      join
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_g.size() + exp_r0.size() + exp_r1.size() + exp_w.size() + exp_b0.size() + exp_b1.size()) != 0
             && n < 500) begin
         @(posedge aclk); n++;
      end
      if (n >= 500) fail_msg("drain_timeout");
      repeat (2) @(posedge aclk);
      #1;
   endtask

   task automatic rst_pulse();
      arst = 1'b1;
      repeat (2) @(posedge aclk);
      #1 arst = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
   endtask

   initial begin
      {s0_awvalid, s0_wvalid, s0_arvalid, s1_awvalid, s1_wvalid, s1_arvalid} = 6'b000000;
      {s0_wlast, s1_wlast, s0_awlock, s0_arlock, s1_awlock, s1_arlock} = 6'b000000;
      s0_rready = 1'b1; s0_bready = 1'b1; s1_rready = 1'b1; s1_bready = 1'b1;
      s0_awaddr = 64'd0; s0_araddr = 64'd0; s1_awaddr = 64'd0; s1_araddr = 64'd0;
      s0_awlen = 8'd0; s0_arlen = 8'd0; s1_awlen = 8'd0; s1_arlen = 8'd0;
      s0_awid = 8'd0; s0_arid = 8'd0; s1_awid = 8'd0; s1_arid = 8'd0;
      s0_wdata = 64'd0; s1_wdata = 64'd0; s0_wstrb = 8'd0; s1_wstrb = 8'd0;
      s0_awsize = 3'd3; s0_arsize = 3'd3; s1_awsize = 3'd3; s1_arsize = 3'd3;
      s0_awburst = 2'd1; s0_arburst = 2'd1; s1_awburst = 2'd1; s1_arburst = 2'd1;
      s0_awcache = 4'd0; s0_arcache = 4'd0; s1_awcache = 4'd0; s1_arcache = 4'd0;
      s0_awprot = 3'd0; s0_arprot = 3'd0; s1_awprot = 3'd0; s1_arprot = 3'd0;
      s0_awqos = 4'd0; s0_arqos = 4'd0; s1_awqos = 4'd0; s1_arqos = 4'd0;
      s0_awregion = 4'd0; s0_arregion = 4'd0; s1_awregion = 4'd0; s1_arregion = 4'd0;

      repeat (2) @(negedge aclk);
      chk("reset_outputs", 128'(hs_outs), 128'd0);
      @(posedge aclk); #1 arst = 1'b0;
      repeat (2) @(posedge aclk); #1;

      // s0 4-beat read with 1-cycle arbitration latency.
      push_g(1'b0, 8'h10, 64'h0000_0000_8000_0000, 8'd3);
      push_r(0, 64'h0000_0000_8000_0000, 3, 8'h10, 4);
      fork
         do_read(0, 64'h0000_0000_8000_0000, 8'd3, 8'h10);
         begin
            @(negedge aclk); chk("arvalid_lat_c0", 128'(mst_arvalid), 128'd0);
            @(negedge aclk); chk("arvalid_lat_c1", 128'(mst_arvalid), 128'd1);
         end
      join
      wait_drain();

      // s1 2-beat write.
      push_g(1'b1, 8'h21, 64'h0000_0000_8000_0100, 8'd1);
      exp_w.push_back(128'({64'h1111_2222_3333_4440, 8'hFF, 1'b0}));
      exp_w.push_back(128'({64'h1111_2222_3333_4441, 8'h0F, 1'b1}));
      exp_b1.push_back(128'({8'h21, 2'b00}));
      do_write(1, 64'h0000_0000_8000_0100, 8'd1, 8'h21, 64'h1111_2222_3333_4440);
      wait_drain();

      // Both masters request reads in the same cycle, two each.
      rst_pulse();
`ifdef ARB_RR_EN
      push_g(1'b0, 8'h10, 64'h0000_0000_8000_0200, 8'd1);
      push_g(1'b0, 8'h20, 64'h0000_0000_8000_0400, 8'd1);
      push_g(1'b0, 8'h11, 64'h0000_0000_8000_0300, 8'd0);
      push_g(1'b0, 8'h21, 64'h0000_0000_8000_0500, 8'd0);
`else
      push_g(1'b0, 8'h10, 64'h0000_0000_8000_0200, 8'd1);
      push_g(1'b0, 8'h11, 64'h0000_0000_8000_0300, 8'd0);
      push_g(1'b0, 8'h20, 64'h0000_0000_8000_0400, 8'd1);
      push_g(1'b0, 8'h21, 64'h0000_0000_8000_0500, 8'd0);
`endif
      push_r(0, 64'h0000_0000_8000_0200, 1, 8'h10, 2);
      push_r(0, 64'h0000_0000_8000_0300, 0, 8'h11, 1);
      push_r(1, 64'h0000_0000_8000_0400, 1, 8'h20, 2);
      push_r(1, 64'h0000_0000_8000_0500, 0, 8'h21, 1);
      fork
         begin
            do_read(0, 64'h0000_0000_8000_0200, 8'd1, 8'h10);
            do_read(0, 64'h0000_0000_8000_0300, 8'd0, 8'h11);
         end
         begin
            do_read(1, 64'h0000_0000_8000_0400, 8'd1, 8'h20);
            do_read(1, 64'h0000_0000_8000_0500, 8'd0, 8'h21);
         end
      join
      wait_drain();

      // s0 AR and AW together: read first, write data held back until AW handshake.
      push_g(1'b0, 8'h12, 64'h0000_0000_8000_0600, 8'd0);
      push_g(1'b1, 8'h13, 64'h0000_0000_8000_0700, 8'd0);
      push_r(0, 64'h0000_0000_8000_0600, 0, 8'h12, 1);
      exp_w.push_back(128'({64'hABCD_0000_0000_0010, 8'hFF, 1'b1}));
      exp_b0.push_back(128'({8'h13, 2'b00}));
      fork
         do_read(0, 64'h0000_0000_8000_0600, 8'd0, 8'h12);
         do_write(0, 64'h0000_0000_8000_0700, 8'd0, 8'h13, 64'hABCD_0000_0000_0010);
      join
      wait_drain();

      // s1 out-of-range read: SLVERR passes through.
      push_g(1'b0, 8'h22, 64'h0000_0000_0000_1000, 8'd1);
      push_r(1, 64'h0000_0000_0000_1000, 1, 8'h22, 2);
      do_read(1, 64'h0000_0000_0000_1000, 8'd1, 8'h22);
      wait_drain();

      // Reset during the second beat of a 4-beat s0 read.
      push_g(1'b0, 8'h14, 64'h0000_0000_8000_0800, 8'd3);
      push_r(0, 64'h0000_0000_8000_0800, 3, 8'h14, 2);
      do_read(0, 64'h0000_0000_8000_0800, 8'd3, 8'h14);
      begin
         int n;
         n = 0;
         @(negedge aclk);
         while (!s0_rvalid && n < 50) begin @(negedge aclk); n++; end
         if (n >= 50) fail_msg("rbeat_timeout");
      end
      @(posedge aclk);
      @(negedge aclk);
      #2 arst = 1'b1;
      #1 chk("reset_mid_txn_outputs", 128'(hs_outs), 128'd0);
      @(posedge aclk); #1 arst = 1'b0;
      repeat (2) @(posedge aclk); #1;
      push_g(1'b0, 8'h23, 64'h0000_0000_8000_0900, 8'd0);
      push_r(1, 64'h0000_0000_8000_0900, 0, 8'h23, 1);
      do_read(1, 64'h0000_0000_8000_0900, 8'd0, 8'h23);
      wait_drain();

      chk("invariant_violations", 128'(viol), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/axi_sram_arbiter.md
# axi_sram_arbiter

Two-master AXI4 arbiter placed in front of the single-port AXI SRAM slave. It lets an instruction-fetch master (s0) and a load/store master (s1) share the slave, which services only one transaction at a time. The arbiter grants a whole transaction (AR+R burst, or AW+W+B) to one master and holds the grant until that transaction's final handshake.

## Interface
- AXI_ADDR_W, 64, address width
- AXI_ID_W, 8, ID width, identical on both sides; IDs pass through unmodified
- AXI_DATA_W, 64, data width
- aclk  in  1  clock, all logic on rising edge
- arst  in  1  asynchronous, active-high reset
- sN_aw{valid,addr,len,size,burst,lock,cache,prot,qos,region,id}  in  AXI widths  write address from master N (N=0,1)
- sN_awready  out  1  write address ready to master N
- sN_w{valid,last,data,strb}  in  AXI widths  write data from master N
- sN_wready  out  1
- sN_bvalid, sN_bid, sN_bresp  out  1/AXI_ID_W/2  write response to master N
- sN_bready  in  1
- sN_ar{valid,addr,len,size,burst,lock,cache,prot,qos,region,id}  in  AXI widths  read address from master N
- sN_arready  out  1
- sN_rvalid, sN_rid, sN_rresp, sN_rdata, sN_rlast  out  1/AXI_ID_W/2/AXI_DATA_W/1  read data to master N
- sN_rready  in  1
- mst_*  full AXI4 master port toward the SRAM slave, same signal set and widths as the slave's port

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP. Registers: state, grant (1 bit), rr_ptr (1 bit).
- IDLE: requests considered are s0_arvalid, s0_awvalid, s1_arvalid, s1_awvalid. Master selection per Configuration; within the selected master a pending AR beats a pending AW. On any request: latch grant, go RD_ADDR or WR_ADDR. No request: stay.
- RD_ADDR: mst_ar* = granted sN_ar*; sN_arready = mst_arready for granted N only. On mst_arvalid&mst_arready -> RD_DATA.
- RD_DATA: mst_r* routed to granted master; mst_rready = granted sN_rready. On rvalid&rready&rlast -> IDLE, rr_ptr <= ~grant.
- WR_ADDR: AW forwarded as for AR. On handshake -> WR_DATA.
- WR_DATA: W forwarded from granted master only. On wvalid&wready&wlast -> WR_RESP.
- WR_RESP: B routed to granted master. On bvalid&bready -> IDLE, rr_ptr <= ~grant.
- Ungranted master: all readies 0, all valids 0. rdata/rid/rresp/rlast/bid/bresp may be broadcast to both; only valid is qualified.
- mst_*valid driven 0 in every state not owning that channel; other mst_* payloads may carry granted master's inputs.
- Slave error responses pass through untouched; arbiter generates no responses itself.
- A master deasserting valid before handshake (protocol violation) leaves the arbiter waiting; no recovery.

## Timing
- Reset: state IDLE, grant 0, rr_ptr 0; every ready/valid output 0.
- Arbitration latency: 1 cycle (request seen in IDLE, forwarded on mst_* next cycle). All forwarding within a granted state is combinational, zero added latency.
- Back-to-back: after last R or B handshake, earliest next mst_arvalid/awvalid is 2 cycles later (IDLE cycle, then ADDR state).
- Simultaneous requests from both masters in IDLE: resolved by selection rule; loser holds valid and is granted next.
- Simultaneous AR and AW from same master: AR first, AW next arbitration round (subject to selection rule).
- Reset mid-transaction: immediate return to IDLE with outputs 0; the slave is reset by the same system reset.

## Configuration
- ARB_RR_EN defined: round-robin; in IDLE, master rr_ptr wins if requesting, else the other. rr_ptr flips to non-granted master after each completed transaction.
- ARB_RR_EN undefined: fixed priority, s0 always wins when requesting; rr_ptr not implemented.

## Test plan
- Single s0 read, araddr 0x8000_0000, arlen 3 -> mst_arvalid 1 cycle after s0_arvalid; 4 beats delivered to s0 with rlast on beat 4; s1_rvalid stays 0.
- s1 write, awaddr 0x8000_0100, awlen 1, 2 W beats -> bresp 2'b00 delivered on s1_bvalid only; s0 sees no readies throughout.
- s0 and s1 both assert arvalid same cycle, repeated 4 transactions, ARB_RR_EN defined -> grant order s0,s1,s0,s1; undefined -> s0 wins every time s0 requests.
- s0 asserts arvalid and awvalid together -> read completes first, then write; wdata never forwarded before mst_aw handshake.
- s1 read to 0x1000 (out of range) -> slave rresp 2'b10 passed to s1_rresp unchanged; arbiter returns to IDLE after rlast.
- arst pulsed during RD_DATA beat 2 -> all valid/ready outputs 0 same cycle; after release, new s1 request granted normally.
